// File: rtl/p08_muldiv4_seq.sv
`default_nettype none
// ============================================================================
// Module   : p08_muldiv4_seq
// Purpose  : Sequential 4-bit unsigned multiply / divide engine.
//            Multiply uses shift-add with one step per multiplier bit.
//            Divide uses restoring division with one step per quotient bit.
//            Each step drives one 4-bit add or trial-subtract and registers
//            the sum/carry it consumes.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset
//            start  - operation request, sampled only in IDLE
//            op     - 0 = multiply, 1 = divide (latched with start)
//            a      - multiplicand / dividend (latched with start)
//            b      - multiplier / divisor (latched with start)
//            busy   - high while an operation is in progress
//            done   - one-cycle pulse, result valid from this cycle
//            result - multiply: product; divide: {remainder, quotient}
//            dbz    - divide-by-zero flag for the current result
// Revision : 1.0 - initial release
// ============================================================================
module p08_muldiv4_seq #(
  parameter int WIDTH = 4,
  parameter int STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               dbz
);

  localparam int               c_cnt_w = $clog2(STEPS);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 op_q, op_d;
  // hi: multiply accumulator upper half / divide partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  // opnd: multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;

  // Datapath for one iteration
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_trial;
  logic                 div_neg;
  logic [WIDTH-1:0]     step_hi;
  logic [WIDTH-1:0]     step_lo;

  always_comb begin
    // Add the multiplicand only when the current multiplier bit is set;
    // the carry is kept so the right shift brings it into the accumulator.
    mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
    // Remainder shifted left with the next dividend bit; one extra bit
    // on the trial so its sign can be tested even for large remainders.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    div_neg   = div_trial[WIDTH+1];
    if (op_q) begin
      step_hi = div_neg ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_neg};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          hi_d    = '0;
          // Multiply shifts the multiplier out of lo; divide shifts the
          // dividend out of lo while the quotient shifts in behind it.
          lo_d    = op ? a : b;
          opnd_d  = op ? b : a;
          dbz_d   = op && (b == '0);
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last_step) begin
          state_d  = S_DONE;
          // Both operations leave their answer as {hi, lo}
          result_d = {step_hi, step_lo};
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign dbz    = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_p08_muldiv4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_p08_muldiv4_seq
// Purpose  : Self-checking bench for p08_muldiv4_seq. Directed vectors from
//            a table, random operations against an arithmetic reference,
//            plus hand-written start-while-busy and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p08_muldiv4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       dbz;

  int n_checks = 0;
  int n_errors = 0;

  p08_muldiv4_seq #(.WIDTH(4), .STEPS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_result;
    logic       exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic; divide by zero gives
  // quotient all-ones and remainder equal to the dividend.
  function automatic logic [7:0] ref_result(input logic o, input logic [3:0] x, input logic [3:0] y);
    int q, r;
    if (!o) return 8'(int'(x) * int'(y));
    if (y == 0) return {x, 4'hF};
    q = int'(x) / int'(y);
    r = int'(x) % int'(y);
    return {4'(r), 4'(q)};
  endfunction

  // Full transaction with cycle-exact timing checks. Inputs are scrambled
  // after the start edge to show they were latched.
  task automatic run_op(input string name, input logic o, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] er, input logic ed);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; a = 4'($urandom); b = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({name, ".busy"}, 32'(busy), 32'd1);
      chk({name, ".nodone"}, 32'(done), 32'd0);
      if (i == 0) chk({name, ".dbz_early"}, 32'(dbz), 32'(ed));
      @(posedge clk);
      #1;
    end
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".busy_off"}, 32'(busy), 32'd0);
    chk({name, ".result"}, 32'(result), 32'(er));
    chk({name, ".dbz"}, 32'(dbz), 32'(ed));
    @(posedge clk);
    #1;
    chk({name, ".done_pulse"}, 32'(done), 32'd0);
    chk({name, ".hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int ndone;
    logic       ro;
    logic [3:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;

    vecs[0] = '{1'b0, 4'd13, 4'd11, 8'h8F, 1'b0};
    vecs[1] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  4'd9,  8'h00, 1'b0};
    vecs[3] = '{1'b0, 4'd1,  4'd1,  8'h01, 1'b0};
    vecs[4] = '{1'b1, 4'd13, 4'd3,  8'h14, 1'b0};
    vecs[5] = '{1'b1, 4'd2,  4'd7,  8'h20, 1'b0};
    vecs[6] = '{1'b1, 4'd15, 4'd1,  8'h0F, 1'b0};
    vecs[7] = '{1'b1, 4'd7,  4'd0,  8'h7F, 1'b1};
    vecs[8] = '{1'b0, 4'd2,  4'd3,  8'h06, 1'b0};
    vecs[9] = '{1'b1, 4'd15, 4'd0,  8'hFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.dbz", 32'(dbz), 32'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_result, vecs[i].exp_dbz);

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_result(ro, ra, rb),
             ro && (rb == 4'd0));
    end

    // Start held high through RUN and DONE: only the first is accepted.
    @(negedge clk);
    op = 1'b0; a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk);
    #1;
    op = 1'b1; a = 4'd9; b = 4'd9;
    ndone = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (i == 4) chk("busystart.result", 32'(result), 32'h0F);
      if (i == 4) chk("busystart.dbz", 32'(dbz), 32'd0);
    end
    chk("busystart.ndone", 32'(ndone), 32'd1);
    chk("busystart.idle", 32'(busy), 32'd0);
    run_op("busystart.next", 1'b0, 4'd4, 4'd4, 8'h10, 1'b0);

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    op = 1'b1; a = 4'd5; b = 4'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort.dbz_set", 32'(dbz), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.result", 32'(result), 32'd0);
    chk("abort.dbz", 32'(dbz), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("abort.quiet", 32'(ndone), 32'd0);
    run_op("abort.after", 1'b0, 4'd6, 4'd7, 8'h2A, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
